therm_seq_decoder: RTL and testbench



---
 rtl/therm_pkg.sv | 14 +
 rtl/therm_seq_decoder_if.sv | 23 ++
 rtl/therm_bit_scanner.sv | 65 ++++++
 rtl/therm_seq_decoder.sv | 80 ++++++++
 tb/tb_therm_seq_decoder.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/therm_pkg.sv
// Shared thermometer-code definitions: widths and the decoder FSM state type.
// Shared by the thermometer encoder, the sequential decoder and the testbench.
package therm_pkg;

  localparam int K = 3;
  localparam int W = 2**K - 1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

endpackage

// File: rtl/therm_seq_decoder_if.sv
// Request/result bundle of the sequential thermometer decoder.
// The master drives start/therm; the slave returns busy/done/bin/err.
interface therm_seq_decoder_if;
  import therm_pkg::*;

  logic         start;
  logic [W-1:0] therm;
  logic         busy;
  logic         done;
  logic [K-1:0] bin;
  logic         err;

  modport master (
    output start, therm,
    input  busy, done, bin, err
  );

  modport slave (
    input  start, therm,
    output busy, done, bin, err
  );

endinterface

// File: rtl/therm_bit_scanner.sv
// LSB-first bit scanner: shift register, index, leading-ones count, bubble flag.
// THERM_EARLY_EXIT_EN: last also fires on the first zero; no bubble tracking.
module therm_bit_scanner
  import therm_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] therm,
  output logic         last,
  output logic [K-1:0] cnt_next,
  output logic         err_next
);

  logic [W-1:0] sh;
  logic [K-1:0] idx;
  logic [K-1:0] cnt;
  logic         zero_seen;
  logic         cur;

  assign cur      = sh[0];
  assign cnt_next = (cur && !zero_seen) ? cnt + K'(1) : cnt;

`ifdef THERM_EARLY_EXIT_EN
  // the bit under examination ends the scan if it is the first zero
  assign last     = (idx == K'(W - 1)) || (!cur && !zero_seen);
  assign err_next = 1'b0;
`else
  logic err_i;

  assign last     = (idx == K'(W - 1));
  assign err_next = err_i | (cur & zero_seen);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_i <= 1'b0;
    end else if (load) begin
      err_i <= 1'b0;
    end else if (step) begin
      err_i <= err_next;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh        <= '0;
      idx       <= '0;
      cnt       <= '0;
      zero_seen <= 1'b0;
    end else if (load) begin
      sh        <= therm;
      idx       <= '0;
      cnt       <= '0;
      zero_seen <= 1'b0;
    end else if (step) begin
      sh        <= sh >> 1;
      idx       <= idx + K'(1);
      cnt       <= cnt_next;
      zero_seen <= zero_seen | ~cur;
    end
  end

endmodule

// File: rtl/therm_seq_decoder.sv
// Sequential thermometer-to-binary decoder: FSM plus result registers.
// Optional THERM_EARLY_EXIT_EN stops the scan at the first zero bit.
module therm_seq_decoder
  import therm_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  therm_seq_decoder_if.slave  bus
);

  state_t       state;
  state_t       state_nx;
  logic         load;
  logic         step;
  logic         last;
  logic         err_next;
  logic [K-1:0] cnt_next;
  logic [K-1:0] bin_q;
  logic         err_q;

  therm_bit_scanner u_scan (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .step     (step),
    .therm    (bus.therm),
    .last     (last),
    .cnt_next (cnt_next),
    .err_next (err_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start) state_nx = SCAN;
      SCAN:    if (last)      state_nx = DONE;
      DONE:                   state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_comb begin
    load     = 1'b0;
    step     = 1'b0;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    unique case (1'b1)
      (state == IDLE): load = bus.start;
      (state == SCAN): begin
        step     = 1'b1;
        bus.busy = 1'b1;
      end
      (state == DONE): begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: ;
    endcase
  end

  // results latch on the final scan edge and hold until the next decode ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q <= '0;
      err_q <= 1'b0;
    end else if (step && last) begin
      bin_q <= cnt_next;
      err_q <= err_next;
    end
  end

  assign bus.bin = bin_q;
  assign bus.err = err_q;

endmodule

// File: tb/tb_therm_seq_decoder.sv
// Scoreboard bench for therm_seq_decoder; expectations from a bit-loop model.
module tb_therm_seq_decoder;
  import therm_pkg::*;

  typedef struct {
    logic [W-1:0] code;
    logic [K-1:0] bin;
    logic         err;
    int           lat;
    int           t0;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  therm_seq_decoder_if bus();

  therm_seq_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t sb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   done_cnt = 0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  function automatic exp_t model(input logic [W-1:0] v);
    exp_t e;
    bit   z   = 1'b0;
    bit   b   = 1'b0;
    int   n   = 0;
    int   lat = W;
    for (int i = 0; i < W; i++) begin
      if (v[i]) begin
        if (z) b = 1'b1;
        else   n++;
      end else begin
`ifdef THERM_EARLY_EXIT_EN
        if (!z) lat = i + 1;
`endif
        z = 1'b1;
      end
    end
`ifdef THERM_EARLY_EXIT_EN
    b = 1'b0;
`endif
    e.code = v;
    e.bin  = K'(n);
    e.err  = b;
    e.lat  = lat;
    e.t0   = 0;
    return e;
  endfunction

  // scoreboard consumer: every done pulse must match the oldest request
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n && bus.done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done bin=%0d err=%b", bus.bin, bus.err);
      end else begin
        e = sb.pop_front();
        checks++;
        if (bus.bin !== e.bin) begin
          errors++;
          $display("FAIL bin code=%b got=%0d exp=%0d",
                   e.code, bus.bin, e.bin);
        end
        checks++;
        if (bus.err !== e.err) begin
          errors++;
          $display("FAIL err code=%b got=%b exp=%b",
                   e.code, bus.err, e.err);
        end
        checks++;
        if (cyc - e.t0 !== e.lat) begin
          errors++;
          $display("FAIL latency code=%b got=%0d exp=%0d",
                   e.code, cyc - e.t0, e.lat);
        end
      end
    end
  end

  task automatic issue(input logic [W-1:0] v);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (bus.busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) begin
      checks++;
      errors++;
      $display("FAIL issue_wait busy=%b exp=0", bus.busy);
    end
    e    = model(v);
    e.t0 = cyc + 1;
    sb.push_back(e);
    bus.start = 1'b1;
    bus.therm = v;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start got=%b exp=1", bus.busy);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.therm = '0;
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy got=%b exp=0", bus.busy);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL rst_done got=%b exp=0", bus.done);
    end
    checks++;
    if (bus.bin !== '0) begin
      errors++;
      $display("FAIL rst_bin got=%0d exp=0", bus.bin);
    end
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL rst_err got=%b exp=0", bus.err);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_rst busy=%b done=%b exp=0/0",
               bus.busy, bus.done);
    end
  endtask

  task automatic test_basic();
    issue(7'b0000111);
    wait_drain();
  endtask

  task automatic test_extremes();
    issue(7'b0000000);
    wait_drain();
    issue(7'b1111111);
    wait_drain();
  endtask

  task automatic test_bubble();
    issue(7'b0010111);
    wait_drain();
    issue(7'b0000001);
    wait_drain();
  endtask

  task automatic test_busy_start();
    int d0 = done_cnt;
    issue(7'b0000111);
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_mid_scan got=%b exp=1", bus.busy);
    end
    bus.start = 1'b1;
    bus.therm = 7'b1111111;
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain();
    repeat (12) @(negedge clk);
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL busy_start_pulses got=%0d exp=1", done_cnt - d0);
    end
  endtask

  task automatic test_midscan_reset();
    int d0;
    issue(7'b1111111);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    d0 = done_cnt;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL abort_ctl busy=%b done=%b exp=0/0",
               bus.busy, bus.done);
    end
    checks++;
    if (bus.bin !== '0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL abort_res bin=%0d err=%b exp=0/0",
               bus.bin, bus.err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (done_cnt !== d0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_quiet pulses=%0d busy=%b exp=0/0",
               done_cnt - d0, bus.busy);
    end
    issue(7'b0000011);
    wait_drain();
  endtask

  task automatic test_early_exit();
    issue(7'b0000111);
    wait_drain();
    issue(7'b0010111);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      issue(W'($urandom_range(0, 2**W - 1)));
    end
    issue(7'b0111111);
    issue(7'b1011111);
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_bubble();
    test_busy_start();
    test_midscan_reset();
    test_early_exit();
    test_back_to_back();
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d exp=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
